ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Load/store initiator that drives the data RAM's port (read_ram, write_ram, ram_addr, ram_write_data, ram_out) on behalf of the CPU core. It accepts one byte-addressed load or store of byte, half, or word size. It converts the byte address to a RAM word index and performs read-modify-write for sub-word stores. It also aligns and sign- or zero-extends load data. It sits between the execute stage and the RAM.

Parameters:
RAM_WORDS, 16, number of 32-bit words in the attached RAM; a word index >= RAM_WORDS is an access error.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  controller can accept (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  aligned and extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned, illegal size, or out of range
read_ram  out  1  RAM read strobe
write_ram  out  1  RAM write strobe
ram_addr  out  32  RAM word index = req_addr >> 2
ram_write_data  out  32  full word to write
ram_out  in  32  RAM read data, sampled one cycle after read_ram asserted

Behaviour:
- Reset (async, rst_n low): state = IDLE.
  - req_ready = 1 (drops to 0 on release only if a request is accepted later).
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - read_ram = 0, write_ram = 0, ram_addr = 0, ram_write_data = 0.
  - Any in-flight request is dropped and gets no response. Strobes deassert immediately, without waiting for clk.
- Request capture: a request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge. req_ready = (state == IDLE).
- Error check at accept:
  - req_size == 11.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - (addr >> 2) >= RAM_WORDS.
  - On error: go directly to RESP with resp_err = 1 and no RAM strobes.
- States: IDLE, RD, CAP, WR, RESP.
  - IDLE -> RD on load or sub-word store.
  - IDLE -> WR on word store.
  - IDLE -> RESP on error.
  - RD: read_ram = 1 for exactly one cycle; -> CAP.
  - CAP: sample ram_out.
    - Load: extract lane, extend, -> RESP.
    - Sub-word store: merge new lane into sampled word, -> WR.
  - WR: write_ram = 1 for exactly one cycle, with ram_write_data = merged or full word; -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle; -> IDLE. No backpressure on the response.
- Latency from accept edge T:
  - Load: response at T+3.
  - Word store: response at T+2.
  - Sub-word store: response at T+4.
  - Error: response at T+1.
- read_ram and write_ram are never high in the same cycle.
- ram_addr and ram_write_data are held stable from RD through WR and return to 0 in IDLE.
- Byte lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1] (low half when 0).
  - Extension: sign bit is bit 7 (byte) or bit 15 (half) unless req_unsigned. Word loads ignore req_unsigned.
  - Sub-word merge replaces only the addressed lane bits. Other lanes keep the value read in CAP.
- req_valid while not IDLE is ignored; it is neither latched nor queued.
- Back-to-back: a new request can be accepted in the IDLE cycle that follows RESP.
- resp_rdata holds its last value between pulses and is only meaningful while resp_valid is high.

Test Plan:
1. Load word: RAM word k preloaded with k. Load word at addr 0x14 (accept T) -> read_ram at T+1, ram_addr = 5, resp_valid at T+3, resp_rdata = 0x00000005, resp_err = 0.
2. Byte store: store byte req_wdata = 0x000000AB at addr 0x0D -> RD with ram_addr = 3, then WR with ram_write_data = 0x0000AB03, resp at T+4. Follow-up load word at 0x0C -> 0x0000AB03.
3. Byte load extension: after scenario 2, signed byte load at 0x0D -> 0xFFFFFFAB; unsigned -> 0x000000AB. Signed half load at 0x0E -> 0x00000000.
4. Errors: half load at 0x03, word store at 0x06, size 11 at 0x00, word load at 0x40 (RAM_WORDS = 16) -> each gives resp_valid with resp_err = 1 at T+1, read_ram = write_ram = 0 throughout, resp_rdata = 0.
5. Word store at 0x08 with 0xDEADBEEF -> write_ram at T+1 only (no read_ram), ram_write_data = 0xDEADBEEF, resp at T+2. req_valid held high during busy -> exactly one accept per IDLE.
6. Reset mid-op: assert rst_n = 0 while in CAP of a sub-word store -> strobes drop asynchronously, no write_ram, no resp_valid. RAM word unchanged; req_ready = 1 after release.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl_if
// Bundles the core-side load/store handshake and the data RAM port of the
// RAM access controller.
//   req_*          : core request (valid/ready handshake, fields latched on accept)
//   resp_*         : one-cycle response pulse with load data and error flag
//   read_ram/write_ram/ram_addr/ram_write_data : RAM command outputs
//   ram_out        : RAM read data, valid one cycle after read_ram
// Modports:
//   slave  : the controller's view
//   master : the core/RAM environment's view
// ---------------------------------------------------------------------------
interface ram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        read_ram;
    logic        write_ram;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_out;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  ram_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output read_ram, write_ram, ram_addr, ram_write_data
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output ram_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  read_ram, write_ram, ram_addr, ram_write_data
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// ram_access_ctrl
// Load/store initiator between the execute stage and the data RAM. Accepts
// one byte-addressed byte/half/word access at a time, converts the byte
// address to a word index, performs read-modify-write for sub-word stores,
// and aligns and sign/zero-extends load data.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (drops all strobes immediately)
//   bus   : ram_access_ctrl_if.slave (request, response and RAM port)
// Parameter:
//   RAM_WORDS : number of 32-bit words in the RAM; larger indices are errors
// ---------------------------------------------------------------------------
module ram_access_ctrl #(
    parameter int RAM_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_read_ram;
    logic        r_write_ram;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_write_data;

    logic [31:0] w_word_idx;
    logic        w_err;
    logic        w_word_store;

    // Select the addressed lane of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the word read back from RAM.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Decode the incoming request: word index, access error and path selection.
    always_comb begin
        w_word_idx   = {2'b00, bus.req_addr[31:2]};
        w_word_store = bus.req_store && (bus.req_size == 2'b10);
        w_err        = 1'b0;
        case (bus.req_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = bus.req_addr[0];
            2'b10:   w_err = (bus.req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
        if (w_word_idx >= 32'(RAM_WORDS)) begin
            w_err = 1'b1;
        end else begin
            w_err = w_err;
        end
    end

    // Access sequencer: request latch, RAM command generation and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_store          <= 1'b0;
            r_size           <= 2'b00;
            r_unsigned       <= 1'b0;
            r_lane           <= 2'b00;
            r_wdata          <= 32'h0000_0000;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'h0000_0000;
            r_resp_err       <= 1'b0;
            r_read_ram       <= 1'b0;
            r_write_ram      <= 1'b0;
            r_ram_addr       <= 32'h0000_0000;
            r_ram_write_data <= 32'h0000_0000;
        end else begin
            // Strobes and the response are single-cycle pulses.
            r_read_ram   <= 1'b0;
            r_write_ram  <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_store     <= bus.req_store;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_lane      <= bus.req_addr[1:0];
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end else if (w_word_store) begin
                            // Full-word store needs no read-back.
                            r_state          <= ST_WR;
                            r_write_ram      <= 1'b1;
                            r_ram_addr       <= w_word_idx;
                            r_ram_write_data <= bus.req_wdata;
                        end else begin
                            r_state    <= ST_RD;
                            r_read_ram <= 1'b1;
                            r_ram_addr <= w_word_idx;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                end
                ST_CAP: begin
                    if (r_store) begin
                        r_state          <= ST_WR;
                        r_write_ram      <= 1'b1;
                        r_ram_write_data <= store_merge(bus.ram_out, r_wdata, r_size, r_lane);
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= load_extract(bus.ram_out, r_size, r_lane, r_unsigned);
                    end
                end
                ST_WR: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                end
                ST_RESP: begin
                    r_state          <= ST_IDLE;
                    r_req_ready      <= 1'b1;
                    r_resp_err       <= 1'b0;
                    r_ram_addr       <= 32'h0000_0000;
                    r_ram_write_data <= 32'h0000_0000;
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_req_ready      <= 1'b1;
                    r_resp_err       <= 1'b0;
                    r_ram_addr       <= 32'h0000_0000;
                    r_ram_write_data <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.read_ram       = r_read_ram;
    assign bus.write_ram      = r_write_ram;
    assign bus.ram_addr       = r_ram_addr;
    assign bus.ram_write_data = r_ram_write_data;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_access_ctrl
// Table-driven directed test of ram_access_ctrl with a behavioural 16-word
// synchronous RAM (word k preloaded with k), plus hand-written sequences for
// held req_valid and asynchronous reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic ram_init;

    always #5 clk = ~clk;

    ram_access_ctrl_if bus ();

    ram_access_ctrl #(.RAM_WORDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural RAM: read data appears the cycle after read_ram.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'(k);
            bus.ram_out <= 32'h0000_0000;
        end else begin
            if (bus.read_ram)  bus.ram_out <= mem[bus.ram_addr[3:0]];
            if (bus.write_ram) mem[bus.ram_addr[3:0]] <= bus.ram_write_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          rd;
        int          wr;
        logic [31:0] raddr;
        logic [31:0] wrdata;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd, input int lat,
                                input logic [31:0] rdat, input logic e, input int rd, input int wr,
                                input logic [31:0] ra, input logic [31:0] wrd);
        vec_t v;
        v.store = st; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.lat = lat; v.rdata = rdat; v.err = e; v.rd = rd; v.wr = wr;
        v.raddr = ra; v.wrdata = wrd;
        return v;
    endfunction

    // Issue one request from an IDLE negedge and observe it up to its response.
    task automatic run_req(input vec_t v, output int lat, output logic [31:0] rdata,
                           output logic err, output int rd, output int wr,
                           output logic [31:0] addr_seen, output logic [31:0] wd_seen,
                           output int both);
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx; rd = 0; wr = 0; both = 0;
        addr_seen = 32'h0000_0000; wd_seen = 32'h0000_0000;
        bus.req_valid    = 1'b1;
        bus.req_store    = v.store;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.read_ram) begin rd++; addr_seen = bus.ram_addr; end
            if (bus.write_ram) begin wr++; addr_seen = bus.ram_addr; wd_seen = bus.ram_write_data; end
            if (bus.read_ram && bus.write_ram) both++;
            if (bus.resp_valid) begin
                lat = n; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
        end
    endtask

    vec_t        vecs [24];
    int          lat, rd, wr, both;
    logic [31:0] rdata, addr_seen, wd_seen;
    logic        err;
    int          acc, wrs, rsps;
    logic        bad;

    initial begin
        // Table: store, size, uns, addr, wdata, lat, rdata, err, rd, wr, ram_addr, write_data
        vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        3, 32'h00000005, 1'b0, 1, 0, 32'd5,  32'h0);
        vecs[1]  = mk(1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AB, 4, 32'h00000000, 1'b0, 1, 1, 32'd3,  32'h0000AB03);
        vecs[2]  = mk(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        3, 32'h0000AB03, 1'b0, 1, 0, 32'd3,  32'h0);
        vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        3, 32'hFFFFFFAB, 1'b0, 1, 0, 32'd3,  32'h0);
        vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        3, 32'h000000AB, 1'b0, 1, 0, 32'd3,  32'h0);
        vecs[5]  = mk(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,        3, 32'h00000000, 1'b0, 1, 0, 32'd3,  32'h0);
        vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);
        vecs[7]  = mk(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);
        vecs[8]  = mk(1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);
        vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);
        vecs[10] = mk(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 2, 32'h00000000, 1'b0, 0, 1, 32'd2,  32'hDEADBEEF);
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1, 0, 32'd2,  32'h0);
        vecs[12] = mk(1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF1234, 4, 32'h00000000, 1'b0, 1, 1, 32'd2,  32'h1234BEEF);
        vecs[13] = mk(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        3, 32'h00001234, 1'b0, 1, 0, 32'd2,  32'h0);
        vecs[14] = mk(1'b0, 2'b01, 1'b0, 32'h08, 32'h0,        3, 32'hFFFFBEEF, 1'b0, 1, 0, 32'd2,  32'h0);
        vecs[15] = mk(1'b0, 2'b01, 1'b1, 32'h08, 32'h0,        3, 32'h0000BEEF, 1'b0, 1, 0, 32'd2,  32'h0);
        vecs[16] = mk(1'b1, 2'b00, 1'b0, 32'h1F, 32'h00000077, 4, 32'h00000000, 1'b0, 1, 1, 32'd7,  32'h77000007);
        vecs[17] = mk(1'b0, 2'b00, 1'b0, 32'h1C, 32'h0,        3, 32'h00000007, 1'b0, 1, 0, 32'd7,  32'h0);
        vecs[18] = mk(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        3, 32'h0000000F, 1'b0, 1, 0, 32'd15, 32'h0);
        vecs[19] = mk(1'b0, 2'b00, 1'b0, 32'h40, 32'h0,        1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);
        vecs[20] = mk(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 4, 32'h00000000, 1'b0, 1, 1, 32'd4,  32'h80000004);
        vecs[21] = mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        3, 32'hFFFFFF80, 1'b0, 1, 0, 32'd4,  32'h0);
        vecs[22] = mk(1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        3, 32'h80000004, 1'b0, 1, 0, 32'd4,  32'h0);
        vecs[23] = mk(1'b1, 2'b01, 1'b0, 32'h01, 32'h0000BEEF, 1, 32'h00000000, 1'b1, 0, 0, 32'd0,  32'h0);

        // Reset
        rst_n = 1'b0; ram_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'h0);
        check("rst read_ram", 32'(bus.read_ram), 32'd0);
        check("rst write_ram", 32'(bus.write_ram), 32'd0);
        check("rst ram_addr", bus.ram_addr, 32'h0);
        check("rst ram_write_data", bus.ram_write_data, 32'h0);
        rst_n = 1'b1; ram_init = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 24; i++) begin
            check($sformatf("v%0d ready before", i), 32'(bus.req_ready), 32'd1);
            run_req(vecs[i], lat, rdata, err, rd, wr, addr_seen, wd_seen, both);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d resp_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d resp_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d read cycles", i), 32'(rd), 32'(vecs[i].rd));
            check($sformatf("v%0d write cycles", i), 32'(wr), 32'(vecs[i].wr));
            check($sformatf("v%0d rd&wr overlap", i), 32'(both), 32'd0);
            if (vecs[i].rd + vecs[i].wr > 0)
                check($sformatf("v%0d ram_addr", i), addr_seen, vecs[i].raddr);
            if (vecs[i].wr > 0)
                check($sformatf("v%0d ram_write_data", i), wd_seen, vecs[i].wrdata);
            @(negedge clk);
            check($sformatf("v%0d resp pulse width", i), 32'(bus.resp_valid), 32'd0);
            check($sformatf("v%0d ready after", i), 32'(bus.req_ready), 32'd1);
            check($sformatf("v%0d ram_addr idle", i), bus.ram_addr, 32'h0);
            check($sformatf("v%0d write_data idle", i), bus.ram_write_data, 32'h0);
        end

        // req_valid held through busy cycles: one accept per IDLE cycle
        acc = 0; wrs = 0; rsps = 0;
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h08; bus.req_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 9; i++) begin
            if (bus.req_valid && bus.req_ready) acc++;
            if (bus.write_ram) wrs++;
            if (bus.resp_valid) rsps++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("hold accepts", 32'(acc), 32'd3);
        check("hold writes", 32'(wrs), 32'd3);
        check("hold responses", 32'(rsps), 32'd3);
        check("hold ready at end", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // Reset while in CAP of a byte store to word 1
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h04; bus.req_wdata = 32'h00000055;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("cap rst read_ram in RD", 32'(bus.read_ram), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("cap rst ready", 32'(bus.req_ready), 32'd1);
        check("cap rst read_ram", 32'(bus.read_ram), 32'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.write_ram || bus.resp_valid) bad = 1'b1;
        end
        rst_n = 1'b1;
        check("cap rst no write/resp", 32'(bad), 32'd0);
        check("cap rst ready after", 32'(bus.req_ready), 32'd1);
        run_req(mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 3, 32'h1, 1'b0, 1, 0, 32'd1, 32'h0),
                lat, rdata, err, rd, wr, addr_seen, wd_seen, both);
        check("cap rst word1 latency", 32'(lat), 32'd3);
        check("cap rst word1 unchanged", rdata, 32'h00000001);
        @(negedge clk);

        // Reset while write_ram is high: strobe drops without a clock edge
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("wr rst write_ram before", 32'(bus.write_ram), 32'd1);
        rst_n = 1'b0;
        #1;
        check("wr rst write_ram async", 32'(bus.write_ram), 32'd0);
        check("wr rst ram_addr async", bus.ram_addr, 32'h0);
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.write_ram || bus.resp_valid) bad = 1'b1;
        end
        rst_n = 1'b1;
        check("wr rst no write/resp", 32'(bad), 32'd0);
        run_req(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'h8, 1'b0, 1, 0, 32'd8, 32'h0),
                lat, rdata, err, rd, wr, addr_seen, wd_seen, both);
        check("wr rst word8 latency", 32'(lat), 32'd3);
        check("wr rst word8 unchanged", rdata, 32'h00000008);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
